// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// State encoding kept as plain 2-bit constants so legacy code can compare against them directly.
package serial_add_ctrl_pkg;

    localparam int WIDTH_DEF = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle for serial_add_ctrl; master issues operands, slave computes.
// No valid/ready pair: start is a level request and done is a one-cycle result strobe.
interface serial_add_ctrl_if
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    logic             start;
    logic             op_sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, op_sub, cin, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, op_sub, cin, a, b,
        output busy, done, sum, cout, ovf
    );

endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// Combinational 1-bit full adder: the single arithmetic cell the serial controller time-shares.
// Zero latency; no flow control.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract, LSB first, one bit per clock; done pulses WIDTH cycles after start is taken.
// No backpressure: start is only sampled in IDLE, so requests while busy are dropped, not queued.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_add_ctrl_if.slave bus
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-2:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             s_bit;
    logic             c_bit;

    fa_cell u_fa (
        .a  (opa[cnt]),
        .b  (opb[cnt]),
        .ci (carry),
        .s  (s_bit),
        .co (c_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // Subtract as a + ~b + 1.
                        opa   <= bus.a;
                        opb   <= bus.op_sub ? ~bus.b : bus.b;
                        carry <= bus.op_sub ? 1'b1 : bus.cin;
                        cnt   <= '0;
                        acc   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    carry <= c_bit;
                    if (cnt == LAST) begin
                        // carry still holds the carry into the MSB at this edge.
                        sum_q  <= {s_bit, acc};
                        cout_q <= c_bit;
                        ovf_q  <= carry ^ c_bit;
                        state  <= DONE;
                    end else begin
                        acc            <= acc >> 1;
                        acc[WIDTH-2]   <= s_bit;
                        cnt            <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed-vector bench for serial_add_ctrl at WIDTH=8: latency, busy length, results, ignored start,
// mid-run reset and back-to-back throughput.
module tb_serial_add_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_add_ctrl_if #(.WIDTH(8)) bus ();

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                         input logic msub, input logic mci);
        int r;
        logic [7:0] bb;
        logic [7:0] s;
        logic       o;
        bb = msub ? (8'hFF - mb) : mb;
        r  = int'(ma) + int'(bb) + (msub ? 1 : int'(mci));
        s  = r[7:0];
        o  = (ma[7] == bb[7]) && (s[7] != ma[7]);
        return {o, r[8], s};
    endfunction

    // Issues one operation and follows it until busy drops; optionally pokes a second start mid-run.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tsub,
                          input logic tci, input bit poke,
                          output int lat, output int bcnt, output int dcnt);
        @(negedge clk);
        bus.a = ta; bus.b = tb_v; bus.op_sub = tsub; bus.cin = tci; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = -1; bcnt = 0; dcnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (!bus.busy) break;
            bcnt++;
            if (bus.done) begin
                dcnt++;
                if (lat < 0) lat = i;
            end
            if (poke && i == 2) begin
                bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; bus.op_sub = 1'b1; bus.cin = 1'b1;
            end
            if (poke && i == 3) begin
                bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h77; bus.op_sub = 1'b0; bus.cin = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int lat, bcnt, dcnt, n, last;
        logic [9:0] exp_r;
        logic [7:0] ba [3];
        logic [7:0] bb [3];
        logic       bs [3];
        logic       bc [3];

        bus.start = 1'b0; bus.op_sub = 1'b0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;

        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_sum",  bus.sum,  0);
        check("rst_cout", bus.cout, 0);
        check("rst_ovf",  bus.ovf,  0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 0x3C + 0x45 + 1
        run_op(8'h3C, 8'h45, 1'b0, 1'b1, 1'b0, lat, bcnt, dcnt);
        check("add_lat",   lat, 8);
        check("add_dcnt",  dcnt, 1);
        check("add_sum",   bus.sum, 8'h82);
        check("add_cout",  bus.cout, 0);
        check("add_ovf",   bus.ovf, 1);

        run_op(8'h10, 8'h20, 1'b1, 1'b0, 1'b0, lat, bcnt, dcnt);
        check("sub1_sum",  bus.sum, 8'hF0);
        check("sub1_cout", bus.cout, 0);
        check("sub1_ovf",  bus.ovf, 0);

        run_op(8'h80, 8'h01, 1'b1, 1'b0, 1'b0, lat, bcnt, dcnt);
        check("sub2_sum",  bus.sum, 8'h7F);
        check("sub2_cout", bus.cout, 1);
        check("sub2_ovf",  bus.ovf, 1);

        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, lat, bcnt, dcnt);
        check("wrap_sum",  bus.sum, 8'h00);
        check("wrap_cout", bus.cout, 1);
        check("wrap_ovf",  bus.ovf, 0);
        check("wrap_busy", bcnt, 9);

        // Second start during RUN must be dropped; 0x12 + 0x34 = 0x46.
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b1, lat, bcnt, dcnt);
        check("ign_sum",  bus.sum, 8'h46);
        check("ign_cout", bus.cout, 0);
        check("ign_ovf",  bus.ovf, 0);
        check("ign_lat",  lat, 8);
        dcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        check("ign_dcnt", dcnt, 1 - 1);

        // Reset at RUN cycle 4.
        @(negedge clk);
        bus.a = 8'h55; bus.b = 8'h22; bus.op_sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy_pre", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_busy", bus.busy, 0);
        check("mid_done", bus.done, 0);
        check("mid_sum",  bus.sum,  0);
        check("mid_cout", bus.cout, 0);
        check("mid_ovf",  bus.ovf,  0);
        dcnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.done || bus.busy) dcnt++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (bus.done || bus.busy) dcnt++;
        end
        check("mid_quiet", dcnt, 0);
        run_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, lat, bcnt, dcnt);
        check("post_rst_sum", bus.sum, 8'h02);
        check("post_rst_lat", lat, 8);

        // Back-to-back with start held high.
        ba[0] = 8'h7F; bb[0] = 8'h01; bs[0] = 1'b0; bc[0] = 1'b0;
        ba[1] = 8'hA5; bb[1] = 8'h5A; bs[1] = 1'b1; bc[1] = 1'b0;
        ba[2] = 8'hC8; bb[2] = 8'h9C; bs[2] = 1'b0; bc[2] = 1'b1;
        @(negedge clk);
        bus.a = ba[0]; bus.b = bb[0]; bus.op_sub = bs[0]; bus.cin = bc[0]; bus.start = 1'b1;
        n = 0; last = 0;
        for (int i = 0; i < 60 && n < 3; i++) begin
            @(negedge clk);
            if (bus.done) begin
                exp_r = model(ba[n], bb[n], bs[n], bc[n]);
                check("b2b_sum",  bus.sum,  exp_r[7:0]);
                check("b2b_cout", bus.cout, exp_r[8]);
                check("b2b_ovf",  bus.ovf,  exp_r[9]);
                if (n > 0) check("b2b_gap", cyc - last, 10);
                last = cyc;
                n++;
                if (n < 3) begin
                    bus.a = ba[n]; bus.b = bb[n]; bus.op_sub = bs[n]; bus.cin = bc[n];
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        check("b2b_count", n, 3);
        check("b2b_ref0", model(8'hA5, 8'h5A, 1'b1, 1'b0), {1'b1, 1'b1, 8'h4B});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
